// File: rtl/cmp_result_filter.sv
// Filters magnitude-comparator flags: qualifies, debounces by persistence, and
// tracks the committed relation plus saturating per-class sample counts.
module cmp_result_filter #(
    parameter int unsigned PERSIST = 3,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             agreat,
    input  logic             aless,
    input  logic             equal,
    input  logic             clr,
    output logic [1:0]       rel,
    output logic             rel_valid,
    output logic             chg,
    output logic             fault,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        UNK = 2'b00,
        GT  = 2'b01,
        LT  = 2'b10,
        EQ  = 2'b11
    } rel_t;

    localparam logic [3:0]       PMAX = 4'(PERSIST);
    localparam logic [CNT_W-1:0] CMAX = '1;

    rel_t       state, state_n;
    rel_t       cand, cand_n;
    rel_t       cls;
    logic       legal;
    logic [3:0] run, run_n;
    logic [4:0] run_inc;
    logic       chg_n, fault_n, rel_valid_n;
    logic       hit_gt, hit_lt, hit_eq, hit_err;

    always_comb begin
        cls   = UNK;
        legal = 1'b0;
        case ({agreat, aless, equal})
            3'b100:  begin cls = GT; legal = 1'b1; end
            3'b010:  begin cls = LT; legal = 1'b1; end
            3'b001:  begin cls = EQ; legal = 1'b1; end
            default: begin cls = UNK; legal = 1'b0; end
        endcase
    end

    // The commit test uses the updated run/candidate, so a commit lands on
    // the same edge that accepts the PERSIST-th matching sample.
    always_comb begin
        state_n = state;
        cand_n  = cand;
        run_n   = run;
        chg_n   = 1'b0;
        fault_n = 1'b0;
        run_inc = {1'b0, run} + 5'd1;
        if (in_valid) begin
            if (!legal) begin
                cand_n  = UNK;
                run_n   = '0;
                fault_n = 1'b1;
            end else begin
                if (cls == cand) begin
                    run_n = (run_inc >= {1'b0, PMAX}) ? PMAX : run_inc[3:0];
                end else begin
                    cand_n = cls;
                    run_n  = 4'd1;
                end
                if ((run_n == PMAX) && (cand_n != state)) begin
                    state_n = cand_n;
                    chg_n   = 1'b1;
                end
            end
        end
        rel_valid_n = (state_n != UNK);
    end

    assign hit_gt  = in_valid && legal && (cls == GT);
    assign hit_lt  = in_valid && legal && (cls == LT);
    assign hit_eq  = in_valid && legal && (cls == EQ);
    assign hit_err = in_valid && !legal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                 input logic hit);
        return (hit && (c != CMAX)) ? c + CNT_W'(1) : c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNK;
            cand      <= UNK;
            run       <= '0;
            rel_valid <= 1'b0;
            chg       <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_n;
            cand      <= cand_n;
            run       <= run_n;
            rel_valid <= rel_valid_n;
            chg       <= chg_n;
            fault     <= fault_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            gt_cnt  <= sat_inc(gt_cnt, hit_gt);
            lt_cnt  <= sat_inc(lt_cnt, hit_lt);
            eq_cnt  <= sat_inc(eq_cnt, hit_eq);
            err_cnt <= sat_inc(err_cnt, hit_err);
        end
    end

    assign rel = state;

endmodule

// File: tb/tb_cmp_result_filter.sv
// Scoreboard bench for cmp_result_filter: default, CNT_W=2 and PERSIST=1
// instances share one directed stimulus stream.
module tb_cmp_result_filter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, agreat = 1'b0, aless = 1'b0, equal = 1'b0, clr = 1'b0;

    logic [1:0] rel0, rel1, rel2;
    logic       rv0, rv1, rv2, chg0, chg1, chg2, flt0, flt1, flt2;
    logic [7:0] gt0, lt0, eq0, er0, gt2, lt2, eq2, er2;
    logic [1:0] gt1, lt1, eq1, er1;

    always #5 clk = ~clk;

    cmp_result_filter u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agreat(agreat), .aless(aless),
        .equal(equal), .clr(clr), .rel(rel0), .rel_valid(rv0), .chg(chg0), .fault(flt0),
        .gt_cnt(gt0), .lt_cnt(lt0), .eq_cnt(eq0), .err_cnt(er0));

    cmp_result_filter #(.CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agreat(agreat), .aless(aless),
        .equal(equal), .clr(clr), .rel(rel1), .rel_valid(rv1), .chg(chg1), .fault(flt1),
        .gt_cnt(gt1), .lt_cnt(lt1), .eq_cnt(eq1), .err_cnt(er1));

    cmp_result_filter #(.PERSIST(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .agreat(agreat), .aless(aless),
        .equal(equal), .clr(clr), .rel(rel2), .rel_valid(rv2), .chg(chg2), .fault(flt2),
        .gt_cnt(gt2), .lt_cnt(lt2), .eq_cnt(eq2), .err_cnt(er2));

    typedef struct {
        int r, rv, c, f, gt, lt, eq, er;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    int pers[3] = '{3, 3, 1};
    int cmax[3] = '{255, 3, 255};
    int m_rel[3], m_cand[3], m_run[3], m_chg[3], m_flt[3];
    int m_gt[3], m_lt[3], m_eq[3], m_er[3];

    localparam bit [2:0] S_GT = 3'b100, S_LT = 3'b010, S_EQ = 3'b001;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    // Reference behaviour for one instance, one clock edge.
    task automatic model_step(input int k, input bit v, input bit [2:0] code,
                              input bit c, input bit r);
        int cl;
        m_chg[k] = 0;
        m_flt[k] = 0;
        if (r) begin
            m_rel[k] = 0; m_cand[k] = 0; m_run[k] = 0;
            m_gt[k] = 0; m_lt[k] = 0; m_eq[k] = 0; m_er[k] = 0;
            return;
        end
        if (v) begin
            cl = (code == S_GT) ? 1 : (code == S_LT) ? 2 : (code == S_EQ) ? 3 : -1;
            if (cl < 0) begin
                m_cand[k] = 0;
                m_run[k]  = 0;
                m_flt[k]  = 1;
                m_er[k]   = sat(m_er[k], cmax[k]);
            end else begin
                if (cl == 1) m_gt[k] = sat(m_gt[k], cmax[k]);
                if (cl == 2) m_lt[k] = sat(m_lt[k], cmax[k]);
                if (cl == 3) m_eq[k] = sat(m_eq[k], cmax[k]);
                if (cl == m_cand[k]) begin
                    if (m_run[k] < pers[k]) m_run[k]++;
                end else begin
                    m_cand[k] = cl;
                    m_run[k]  = 1;
                end
                if (m_run[k] == pers[k] && m_cand[k] != m_rel[k]) begin
                    m_rel[k] = m_cand[k];
                    m_chg[k] = 1;
                end
            end
        end
        if (c) begin
            m_gt[k] = 0; m_lt[k] = 0; m_eq[k] = 0; m_er[k] = 0;
        end
    endtask

    task automatic cmp_one(input int k, input exp_t e, input int r, input int rv,
                           input int c, input int f, input int g, input int l,
                           input int q, input int er);
        string p;
        p = $sformatf("u%0d", k);
        chk({p, ".rel"}, r, e.r);
        chk({p, ".rel_valid"}, rv, e.rv);
        chk({p, ".chg"}, c, e.c);
        chk({p, ".fault"}, f, e.f);
        chk({p, ".gt_cnt"}, g, e.gt);
        chk({p, ".lt_cnt"}, l, e.lt);
        chk({p, ".eq_cnt"}, q, e.eq);
        chk({p, ".err_cnt"}, er, e.er);
    endtask

    task automatic samp(input bit v, input bit [2:0] code, input bit c = 1'b0,
                        input bit r = 1'b0);
        exp_t e;
        in_valid = v;
        {agreat, aless, equal} = code;
        clr = c;
        rst = r;
        for (int k = 0; k < 3; k++) begin
            model_step(k, v, code, c, r);
            e.r = m_rel[k]; e.rv = (m_rel[k] != 0); e.c = m_chg[k]; e.f = m_flt[k];
            e.gt = m_gt[k]; e.lt = m_lt[k]; e.eq = m_eq[k]; e.er = m_er[k];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sbq.size() < 3) begin
            chk("scoreboard_depth", sbq.size(), 3);
        end else begin
            cmp_one(0, sbq.pop_front(), rel0, rv0, chg0, flt0, gt0, lt0, eq0, er0);
            cmp_one(1, sbq.pop_front(), rel1, rv1, chg1, flt1, gt1, lt1, eq1, er1);
            cmp_one(2, sbq.pop_front(), rel2, rv2, chg2, flt2, gt2, lt2, eq2, er2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached before end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        samp(0, 3'b000, 0, 1);
        samp(0, 3'b000, 0, 1);
        chk("rst.rel", rel0, 0);
        chk("rst.rel_valid", rv0, 0);
        chk("rst.lt_cnt", lt0, 0);

        // 3x LT commits LT
        samp(1, S_LT);
        samp(1, S_LT);
        chk("t1.rel_before", rel0, 0);
        samp(1, S_LT);
        chk("t1.rel", rel0, 2);
        chk("t1.rel_valid", rv0, 1);
        chk("t1.chg", chg0, 1);
        chk("t1.lt_cnt", lt0, 3);
        samp(0, 3'b000);
        chk("t1.chg_once", chg0, 0);

        // GT GT LT GT GT GT
        samp(1, S_GT); samp(1, S_GT); samp(1, S_LT);
        samp(1, S_GT); samp(1, S_GT);
        chk("t2.rel_hold", rel0, 2);
        chk("t2.chg_hold", chg0, 0);
        samp(1, S_GT);
        chk("t2.rel", rel0, 1);
        chk("t2.chg", chg0, 1);
        chk("t2.gt_cnt", gt0, 5);

        // EQ EQ illegal EQ EQ EQ
        samp(1, S_EQ); samp(1, S_EQ);
        samp(1, 3'b110);
        chk("t3.fault", flt0, 1);
        chk("t3.err_cnt", er0, 1);
        chk("t3.rel_after_illegal", rel0, 1);
        samp(1, S_EQ); samp(1, S_EQ);
        chk("t3.rel_restart", rel0, 1);
        samp(1, S_EQ);
        chk("t3.rel", rel0, 3);
        chk("t3.chg", chg0, 1);

        // Other illegal codes
        samp(1, 3'b000); samp(1, 3'b111);
        chk("t3.err_cnt2", er0, 3);
        chk("t3.err_sat_w2", er1, 3);

        // CNT_W=2 saturation, then clr with EQ
        for (int i = 0; i < 5; i++) samp(1, S_EQ);
        chk("t4.eq_sat_w2", eq1, 3);
        samp(1, S_EQ, 1);
        chk("t4.eq_clr_w2", eq1, 0);
        chk("t4.eq_clr", eq0, 0);
        chk("t4.rel", rel0, 3);
        chk("t4.chg", chg0, 0);

        // Idle with toggling flags
        for (int i = 0; i < 10; i++) samp(0, 3'($urandom_range(0, 7)));
        chk("t5.idle_rel", rel0, 3);
        samp(1, S_LT); samp(1, S_LT);
        samp(0, 3'b000, 0, 1);
        chk("t5.rst_rel", rel0, 0);
        chk("t5.rst_lt", lt0, 0);
        samp(1, S_LT); samp(1, S_LT);
        chk("t5.run_restart", rel0, 0);
        samp(1, S_LT);
        chk("t5.commit_after_rst", rel0, 2);

        // PERSIST=1 alternating
        for (int i = 0; i < 8; i++) begin
            samp(1, (i % 2 == 0) ? S_GT : S_LT);
            chk("t6.chg", chg2, 1);
            chk("t6.rel", rel2, (i % 2 == 0) ? 1 : 2);
        end
        samp(1, S_LT);
        chk("t6.same_no_chg", chg2, 0);

        // 8-bit saturation
        for (int i = 0; i < 260; i++) samp(1, S_EQ);
        chk("t7.eq_sat_w8", eq0, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
